// File: rtl/control_loop_scheduler.sv
// Armed flight-loop sequencer: per control tick runs the shared PID engine over four axes,
// mixes the corrections with the base throttle into four motor bytes, and ramps down on watchdog failsafe.
module control_loop_scheduler #(
    parameter int LOOP_DIV          = 100000,
    parameter int IMU_TIMEOUT_LOOPS = 50,
    parameter int SRF_TIMEOUT_LOOPS = 200,
    parameter int PID_TIMEOUT       = 255,
    parameter int RAMP_STEP         = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        init_done,
    input  logic        init_error,
    input  logic        arm,
    input  logic        imu_new_data,
    input  logic        srf05_new_data,
    input  logic [7:0]  throttle_base,
    output logic        pid_start,
    output logic [1:0]  pid_sel,
    input  logic        pid_done,
    input  logic [15:0] pid_out,
    output logic [31:0] throttles,
    output logic        motors_start,
    output logic        motors_reset,
    output logic [2:0]  state,
    output logic        failsafe,
    output logic        loop_overrun
);

    // state     | meaning
    // IDLE      | disarmed, motors held in reset
    // WAIT_TICK | armed, waiting for the control tick
    // PID_ISSUE | request PID for axis pid_sel
    // PID_WAIT  | waiting for pid_done
    // MIX       | combine corrections into motor bytes
    // UPDATE    | strobe motor controller
    // FAILSAFE  | ramp throttles to zero on each tick
    // LOCKOUT   | motors off until arm is released
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        PID_ISSUE = 3'd2,
        PID_WAIT  = 3'd3,
        MIX       = 3'd4,
        UPDATE    = 3'd5,
        FAILSAFE  = 3'd6,
        LOCKOUT   = 3'd7
    } state_t;

    localparam int              TW        = (LOOP_DIV > 1) ? $clog2(LOOP_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(LOOP_DIV - 1);
    localparam logic [7:0]      IMU_LIMIT = 8'(IMU_TIMEOUT_LOOPS);
    localparam logic [7:0]      SRF_LIMIT = 8'(SRF_TIMEOUT_LOOPS);
    localparam logic [15:0]     PID_LIMIT = 16'(PID_TIMEOUT - 1);
    localparam logic [7:0]      STEP      = 8'(RAMP_STEP);

    state_t             state_reg, next_state;
    logic [TW-1:0]      tick_cnt;
    logic [7:0]         imu_stale, srf_stale;
    logic [15:0]        pid_wait_cnt;
    logic signed [7:0]  axis [4];
    logic               ramp_pulse;
    logic               running, in_loop, tick, pid_timeout, fs_trig;
    logic signed [10:0] base, roll, pitch, yaw, height;
    logic [31:0]        mix;

    function automatic logic signed [7:0] clip8(input logic signed [15:0] v);
        if (v > 16'sd127)       return 8'sd127;
        else if (v < -16'sd128) return -8'sd128;
        else                    return v[7:0];
    endfunction

    function automatic logic [7:0] clamp255(input logic signed [10:0] v);
        if (v < 11'sd0)          return 8'd0;
        else if (v > 11'sd255)   return 8'hFF;
        else                     return v[7:0];
    endfunction

    function automatic logic [7:0] ramp_down(input logic [7:0] v);
        return (v > STEP) ? v - STEP : 8'd0;
    endfunction

    assign state       = state_reg;
    assign running     = (state_reg != IDLE) && (state_reg != LOCKOUT);
    assign in_loop     = running && (state_reg != FAILSAFE);
    assign tick        = running && (tick_cnt == TICK_LAST);
    assign pid_timeout = (state_reg == PID_WAIT) && !pid_done && (pid_wait_cnt >= PID_LIMIT);
    assign fs_trig     = in_loop && ((imu_stale >= IMU_LIMIT) || (srf_stale >= SRF_LIMIT) || pid_timeout);

    always_ff @(posedge clock) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= next_state;
    end

    always_comb begin
        next_state = state_reg;
        case (state_reg)
            IDLE:      if (init_done && !init_error && arm) next_state = WAIT_TICK;
            WAIT_TICK: if (tick) next_state = PID_ISSUE;
            PID_ISSUE: next_state = PID_WAIT;
            PID_WAIT:  if (pid_done) next_state = (pid_sel == 2'd3) ? MIX : PID_ISSUE;
            MIX:       next_state = UPDATE;
            UPDATE:    next_state = WAIT_TICK;
            FAILSAFE:  if (throttles == 32'd0) next_state = LOCKOUT;
            LOCKOUT:   if (!arm) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (in_loop) begin
            if (fs_trig)   next_state = FAILSAFE;
            else if (!arm) next_state = IDLE;
        end
    end

    always_comb begin
        pid_start    = (state_reg == PID_ISSUE);
        motors_start = (state_reg == UPDATE) || ((state_reg == FAILSAFE) && ramp_pulse);
        motors_reset = (state_reg == IDLE) || (state_reg == LOCKOUT);
        failsafe     = (state_reg == FAILSAFE) || (state_reg == LOCKOUT);
    end

    // Sign-extend corrections into 11 bits so no four-term sum can overflow before clamping.
    always_comb begin
        base   = signed'({3'b000, throttle_base});
        roll   = {{3{axis[0][7]}}, axis[0]};
        pitch  = {{3{axis[1][7]}}, axis[1]};
        yaw    = {{3{axis[2][7]}}, axis[2]};
        height = {{3{axis[3][7]}}, axis[3]};
        mix    = {clamp255(base + height + roll + pitch - yaw),
                  clamp255(base + height - roll + pitch + yaw),
                  clamp255(base + height - roll - pitch - yaw),
                  clamp255(base + height + roll - pitch + yaw)};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt     <= '0;
            imu_stale    <= 8'd0;
            srf_stale    <= 8'd0;
            pid_wait_cnt <= 16'd0;
            loop_overrun <= 1'b0;
            ramp_pulse   <= 1'b0;
        end else begin
            if (!running || tick) tick_cnt <= '0;
            else                  tick_cnt <= tick_cnt + 1'b1;

            if (state_reg == IDLE || imu_new_data)  imu_stale <= 8'd0;
            else if (tick && imu_stale != 8'hFF)    imu_stale <= imu_stale + 8'd1;

            if (state_reg == IDLE || srf05_new_data) srf_stale <= 8'd0;
            else if (tick && srf_stale != 8'hFF)     srf_stale <= srf_stale + 8'd1;

            if (state_reg != PID_WAIT)       pid_wait_cnt <= 16'd0;
            else if (pid_wait_cnt != 16'hFFFF) pid_wait_cnt <= pid_wait_cnt + 16'd1;

            if (state_reg == IDLE) loop_overrun <= 1'b0;
            else if (tick && in_loop && state_reg != WAIT_TICK) loop_overrun <= 1'b1;

            ramp_pulse <= (state_reg == FAILSAFE) && tick;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pid_sel <= 2'd0;
            for (int i = 0; i < 4; i++) axis[i] <= 8'sd0;
        end else if (state_reg == WAIT_TICK) begin
            pid_sel <= 2'd0;
        end else if (state_reg == PID_WAIT && pid_done) begin
            axis[pid_sel] <= clip8(signed'(pid_out));
            if (pid_sel != 2'd3) pid_sel <= pid_sel + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || next_state == IDLE) begin
            throttles <= 32'd0;
        end else if (state_reg == MIX && next_state == UPDATE) begin
            throttles <= mix;
        end else if (state_reg == FAILSAFE && tick) begin
            throttles <= {ramp_down(throttles[31:24]), ramp_down(throttles[23:16]),
                          ramp_down(throttles[15:8]),  ramp_down(throttles[7:0])};
        end
    end

endmodule
